// File: rtl/wallace_mul_pipe_pkg.sv
// Shared definitions for the pipelined Wallace-tree multiplier: widths, latency,
// Baugh-Wooley correction, carry-save layer sizing and the FA/HA cells.
package wallace_mul_pipe_pkg;

    localparam int unsigned MUL_LAT = 3;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mul_mode_e;

    typedef struct packed {
        logic carry;
        logic sum;
    } add_bits_t;

    function automatic int unsigned PW(input int unsigned w);
        return 2 * w;
    endfunction

    // Constant row added in signed mode: ones at columns w and 2w-1.
    function automatic logic [63:0] bw_corr(input int unsigned w);
        logic [63:0] r;
        r = '0;
        r[w]         = 1'b1;
        r[2 * w - 1] = 1'b1;
        return r;
    endfunction

    // Rows left after one layer: each full group of three becomes sum+carry,
    // one or two leftover rows stay as one or two rows.
    function automatic int unsigned csa_next_h(input int unsigned h);
        return 2 * (h / 3) + (h % 3);
    endfunction

    function automatic int unsigned csa_num_layers(input int unsigned h0);
        int unsigned h;
        int unsigned n;
        h = h0;
        n = 0;
        while (h > 2) begin
            h = csa_next_h(h);
            n++;
        end
        return n;
    endfunction

    function automatic int unsigned csa_layer_h(input int unsigned h0, input int unsigned k);
        int unsigned h;
        h = h0;
        for (int unsigned i = 0; i < k; i++) begin
            h = csa_next_h(h);
        end
        return h;
    endfunction

    function automatic add_bits_t full_add(input logic a, input logic b, input logic c);
        add_bits_t r;
        r.sum   = a ^ b ^ c;
        r.carry = (a & b) | (a & c) | (b & c);
        return r;
    endfunction

    function automatic add_bits_t half_add(input logic a, input logic b);
        add_bits_t r;
        r.sum   = a ^ b;
        r.carry = a & b;
        return r;
    endfunction

endpackage

// File: rtl/wallace_csa_layer.sv
// One column-wise Wallace reduction layer: rows grouped in threes through full adders,
// a leftover pair through half adders, a single leftover row passed through.
module wallace_csa_layer
    import wallace_mul_pipe_pkg::*;
#(
    parameter int unsigned HEIGHT = 3,
    parameter int unsigned WIDTH  = 16
) (
    input  logic [HEIGHT*WIDTH-1:0]             rows_in,
    output logic [csa_next_h(HEIGHT)*WIDTH-1:0] rows_out
);

    localparam int unsigned N_FA = HEIGHT / 3;
    localparam int unsigned REM  = HEIGHT % 3;

    logic [2*N_FA*WIDTH-1:0] fa_rows;
    add_bits_t               fa;

    // Carries out of the top column are dropped: the product is taken mod 2^WIDTH.
    always_comb begin
        fa_rows = '0;
        fa      = '0;
        for (int unsigned g = 0; g < N_FA; g++) begin
            for (int unsigned c = 0; c < WIDTH; c++) begin
                fa = full_add(rows_in[(3*g)*WIDTH + c],
                              rows_in[(3*g+1)*WIDTH + c],
                              rows_in[(3*g+2)*WIDTH + c]);
                fa_rows[(2*g)*WIDTH + c] = fa.sum;
                if (c + 1 < WIDTH) begin
                    fa_rows[(2*g+1)*WIDTH + c + 1] = fa.carry;
                end
            end
        end
    end

    if (REM == 0) begin : g_rem
        assign rows_out = fa_rows;
    end else if (REM == 1) begin : g_rem
        assign rows_out = {rows_in[HEIGHT*WIDTH-1 -: WIDTH], fa_rows};
    end else begin : g_rem
        logic [2*WIDTH-1:0] ha_rows;
        add_bits_t          ha;

        always_comb begin
            ha_rows = '0;
            ha      = '0;
            for (int unsigned c = 0; c < WIDTH; c++) begin
                ha = half_add(rows_in[(HEIGHT-2)*WIDTH + c], rows_in[(HEIGHT-1)*WIDTH + c]);
                ha_rows[c] = ha.sum;
                if (c + 1 < WIDTH) begin
                    ha_rows[WIDTH + c + 1] = ha.carry;
                end
            end
        end

        assign rows_out = {ha_rows, fa_rows};
    end

endmodule

// File: rtl/wallace_mul_pipe.sv
// Three-stage valid/ready Wallace-tree multiplier, signed (Baugh-Wooley) or unsigned
// per beat, with an opaque tag carried alongside each operation.
module wallace_mul_pipe
    import wallace_mul_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned PWW      = PW(WIDTH);
    localparam int unsigned H0       = WIDTH + 1;
    localparam int unsigned N_LAYERS = csa_num_layers(H0);
    localparam logic [PWW-1:0] BW_CONST = PWW'(bw_corr(WIDTH));

    logic             v1, v2, v3;
    logic             ld1, ld2, ld3;
    logic [WIDTH-1:0] a1, b1;
    mul_mode_e        mode1;
    logic [TAG_W-1:0] tag1, tag2;
    logic [PWW-1:0]   sum2, carry2;
    logic [H0*PWW-1:0] pp_rows;
    logic [2*PWW-1:0] tree_out;

    // A stage loads when empty or when its occupant moves on this cycle.
    assign ld3       = !v3 || out_ready;
    assign ld2       = !v2 || ld3;
    assign ld1       = !v1 || ld2;
    assign in_ready  = ld1;
    assign out_valid = v3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            a1    <= '0;
            b1    <= '0;
            mode1 <= MODE_UNSIGNED;
            tag1  <= '0;
        end else if (ld1) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1    <= in_a;
                b1    <= in_b;
                mode1 <= mul_mode_e'(in_signed);
                tag1  <= in_tag;
            end
        end
    end

    // Row j holds a[i]&b[j] at column i+j; signed mode inverts the cross terms with
    // exactly one sign bit and appends the correction constant as an extra row.
    always_comb begin
        pp_rows = '0;
        for (int unsigned j = 0; j < WIDTH; j++) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                pp_rows[j*PWW + i + j] = (a1[i] & b1[j]) ^
                    ((mode1 == MODE_SIGNED) && ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
        pp_rows[WIDTH*PWW +: PWW] = (mode1 == MODE_SIGNED) ? BW_CONST : '0;
    end

    for (genvar k = 0; k < N_LAYERS; k++) begin : g_layer
        localparam int unsigned HI = csa_layer_h(H0, k);
        localparam int unsigned HO = csa_next_h(HI);

        logic [HI*PWW-1:0] rows_in;
        logic [HO*PWW-1:0] rows_out;

        if (k == 0) begin : g_src
            assign rows_in = pp_rows;
        end else begin : g_src
            assign rows_in = g_layer[k-1].rows_out;
        end

        wallace_csa_layer #(
            .HEIGHT (HI),
            .WIDTH  (PWW)
        ) u_csa (
            .rows_in  (rows_in),
            .rows_out (rows_out)
        );

        if (k == N_LAYERS - 1) begin : g_sink
            assign tree_out = rows_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            sum2   <= '0;
            carry2 <= '0;
            tag2   <= '0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                sum2   <= tree_out[PWW-1:0];
                carry2 <= tree_out[2*PWW-1:PWW];
                tag2   <= tag1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3       <= 1'b0;
            out_prod <= '0;
            out_tag  <= '0;
        end else if (ld3) begin
            v3 <= v2;
            if (v2) begin
                out_prod <= sum2 + carry2;
                out_tag  <= tag2;
            end
        end
    end

endmodule
